shift_seq_ctrl: RTL and testbench
=================================

SHIFT_SEQ_CTRL -- requirements
Module: shift_seq_ctrl

Interface
REQ-001 Parameter STEP_MAX, default 8, max bits shifted per cycle (power of two, 1..16).
REQ-002 clk  input  1  rising-edge clock, sole clock domain.
REQ-003 rst_n  input  1  synchronous active-low reset.
REQ-004 req_valid_0 / req_valid_1  input  1 each  requester i has an operation pending.
REQ-005 req_ready_0 / req_ready_1  output  1 each  requester i's operation accepted this cycle.
REQ-006 req_a_0 / req_a_1  input  32 each  operand (signed for SRA).
REQ-007 req_shamt_0 / req_shamt_1  input  5 each  shift amount, 0..31.
REQ-008 req_type_0 / req_type_1  input  2 each  00 SLL, 01 SRL, 10 SRA, 11 illegal.
REQ-009 rsp_valid  output  1  result available.
REQ-010 rsp_ready  input  1  consumer takes result.
REQ-011 rsp_data  output  32  shifted result.
REQ-012 rsp_id  output  1  index of the requester that owns the result.
REQ-013 rsp_err  output  1  operation had illegal type 11.

Function
REQ-014 FSM states: IDLE, SHIFT, RESP; only one operation in flight.
REQ-015 IDLE: req_ready_i is combinationally high only for the granted requester, and only when its req_valid_i is high; all req_ready low in SHIFT and RESP.
REQ-016 Arbitration is round-robin: priority pointer selects the preferred requester; if only one is valid it is granted regardless of the pointer.
REQ-017 On acceptance: capture a, type and id, set remaining = shamt; next state SHIFT if shamt != 0, else RESP.
REQ-018 SHIFT: each cycle, step = min(remaining, STEP_MAX); acc = acc shifted by step per the captured type (SLL zero-fill, SRL zero-fill, SRA sign-fill); remaining -= step.
REQ-019 SHIFT -> RESP in the cycle remaining becomes 0.
REQ-020 Latency: acceptance in cycle T yields rsp_valid in cycle T+1+ceil(shamt/STEP_MAX); shamt=0 gives T+1.
REQ-021 Type 11: no shift cycles, rsp_data = captured a, rsp_err = 1; otherwise rsp_err = 0.
REQ-022 RESP: rsp_valid high; rsp_data, rsp_id and rsp_err stable until rsp_valid && rsp_ready.
REQ-023 On the response handshake: go to IDLE; pointer moves to the requester not just served. No acceptance occurs in the handshake cycle.
REQ-024 rsp_valid never depends combinationally on rsp_ready; rsp_* outputs are registered.
REQ-025 A requester must hold its request fields stable while req_valid is high and req_ready is low; a request withdrawn before acceptance is never serviced.

Reset
REQ-026 While rst_n is low at a clock edge: state IDLE, pointer = requester 0, remaining = 0, rsp_valid = 0, rsp_data = 0, rsp_id = 0, rsp_err = 0.
REQ-027 req_ready_0 and req_ready_1 are 0 in any cycle where rst_n is low.
REQ-028 Reset during SHIFT or RESP abandons the operation; no response is ever produced for it.

Structure
REQ-029 The shared package holds the shift-type encodings (SLL, SRL, SRA, ILLEGAL), the FSM state enum, and the STEP_MAX default.
REQ-030 The per-cycle shift uses one instance of the existing combinational shifter sub-module, driven with the captured type and the step; type 11 bypasses it.

Verification
REQ-031 req0 a=0x80000001, shamt=4, SLL, accepted in cycle T -> rsp_data=0x00000010, rsp_id=0, rsp_err=0, rsp_valid in T+2.
REQ-032 req1 a=0x80000000, shamt=31, SRA, STEP_MAX=8 -> rsp_data=0xFFFFFFFF, rsp_id=1, rsp_valid in T+5; the same operand with SRL -> rsp_data=0x00000001.
REQ-033 Both requesters continuously valid after reset -> grants alternate 0,1,0,1; shamt=0 on both -> each response appears one cycle after its acceptance.
REQ-034 rsp_ready held low for 3 cycles in RESP -> rsp_data/rsp_id stable, both req_ready stay 0, and the waiting requester is accepted one cycle after the handshake.
REQ-035 type=11, a=0x12345678, shamt=7 -> rsp_data=0x12345678, rsp_err=1, rsp_valid in T+1.
REQ-036 rst_n low for 1 cycle during SHIFT of shamt=31 -> rsp_valid never asserts for that operation; the next request is serviced normally, with requester 0 preferred.

Source files
------------

// File: rtl/shift_seq_ctrl_pkg.sv
// Shared definitions for the sequential shift controller.
//   - shift_type_e : operation encodings carried on req_type_*
//   - state_e      : controller FSM states
//   - StepMaxDefault : default number of bit positions shifted per cycle
package shift_seq_ctrl_pkg;

  localparam int unsigned StepMaxDefault = 8;
  localparam int unsigned DataW          = 32;
  localparam int unsigned ShamtW         = 5;

  typedef enum logic [1:0] {
    ShSll     = 2'b00,
    ShSrl     = 2'b01,
    ShSra     = 2'b10,
    ShIllegal = 2'b11
  } shift_type_e;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StShift = 2'b01,
    StResp  = 2'b10
  } state_e;

endpackage

// File: rtl/shift_seq_ctrl_shifter.sv
// Combinational single-stage shifter.
//   data   : operand
//   amt    : shift distance (0..31)
//   op     : shift type (SLL / SRL / SRA); the illegal code passes data through
//   result : shifted operand
module shift_seq_ctrl_shifter
  import shift_seq_ctrl_pkg::*;
(
  input  logic [31:0] data,
  input  logic [4:0]  amt,
  input  logic [1:0]  op,
  output logic [31:0] result
);

  always_comb begin
    result = data;
    unique case (shift_type_e'(op))
      ShSll:   result = data << amt;
      ShSrl:   result = data >> amt;
      ShSra:   result = $signed(data) >>> amt;
      default: result = data;
    endcase
  end

endmodule

// File: rtl/shift_seq_ctrl.sv
// Two-requester sequential shift controller.
// Accepts one shift operation at a time from two requesters (round-robin),
// shifts it by at most STEP_MAX bits per cycle, then holds the result until
// the consumer takes it.
//   clk, rst_n              : clock, synchronous active-low reset
//   req_valid_*/req_ready_* : per-requester request handshake
//   req_a_*                 : 32-bit operand
//   req_shamt_*             : shift amount 0..31
//   req_type_*              : 00 SLL, 01 SRL, 10 SRA, 11 illegal
//   rsp_valid/rsp_ready     : response handshake
//   rsp_data/rsp_id/rsp_err : result, owning requester, illegal-type flag
module shift_seq_ctrl
  import shift_seq_ctrl_pkg::*;
#(
  parameter int unsigned STEP_MAX = StepMaxDefault
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid_0,
  input  logic        req_valid_1,
  output logic        req_ready_0,
  output logic        req_ready_1,
  input  logic [31:0] req_a_0,
  input  logic [31:0] req_a_1,
  input  logic [4:0]  req_shamt_0,
  input  logic [4:0]  req_shamt_1,
  input  logic [1:0]  req_type_0,
  input  logic [1:0]  req_type_1,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_id,
  output logic        rsp_err
);

  localparam logic [4:0] StepMax = 5'(STEP_MAX);

  state_e      state_q, state_d;
  logic        ptr_q, ptr_d;
  logic [4:0]  rem_q, rem_d;
  logic [31:0] acc_q, acc_d;
  shift_type_e type_q, type_d;
  logic        id_q, id_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic        rsp_id_q, rsp_id_d;
  logic        rsp_err_q, rsp_err_d;

  logic        any_valid;
  logic        grant_id;
  logic [31:0] sel_a;
  logic [4:0]  sel_shamt;
  shift_type_e sel_type;
  logic [4:0]  step;
  logic [31:0] shifted;

  // Pointer only matters on contention; a lone requester always wins.
  always_comb begin
    any_valid = req_valid_0 | req_valid_1;
    if (req_valid_0 && req_valid_1) begin
      grant_id = ptr_q;
    end else begin
      grant_id = req_valid_1;
    end
    sel_a     = grant_id ? req_a_1 : req_a_0;
    sel_shamt = grant_id ? req_shamt_1 : req_shamt_0;
    sel_type  = shift_type_e'(grant_id ? req_type_1 : req_type_0);
  end

  // Gated by rst_n so no request is accepted in a reset cycle.
  assign req_ready_0 = rst_n && (state_q == StIdle) && req_valid_0 && !grant_id;
  assign req_ready_1 = rst_n && (state_q == StIdle) && req_valid_1 && grant_id;

  assign step = (rem_q > StepMax) ? StepMax : rem_q;

  shift_seq_ctrl_shifter u_shifter (
    .data   (acc_q),
    .amt    (step),
    .op     (type_q),
    .result (shifted)
  );

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    rem_d       = rem_q;
    acc_d       = acc_q;
    type_d      = type_q;
    id_d        = id_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_id_d    = rsp_id_q;
    rsp_err_d   = rsp_err_q;

    unique case (state_q)
      StIdle: begin
        if (any_valid) begin
          acc_d  = sel_a;
          type_d = sel_type;
          id_d   = grant_id;
          rem_d  = sel_shamt;
          if (sel_type == ShIllegal || sel_shamt == 5'd0) begin
            // Nothing to shift: result is the operand itself.
            rem_d       = 5'd0;
            state_d     = StResp;
            rsp_valid_d = 1'b1;
            rsp_data_d  = sel_a;
            rsp_id_d    = grant_id;
            rsp_err_d   = (sel_type == ShIllegal);
          end else begin
            state_d = StShift;
          end
        end
      end

      StShift: begin
        acc_d = shifted;
        rem_d = rem_q - step;
        if (rem_q == step) begin
          state_d     = StResp;
          rsp_valid_d = 1'b1;
          rsp_data_d  = shifted;
          rsp_id_d    = id_q;
          rsp_err_d   = 1'b0;
        end
      end

      StResp: begin
        if (rsp_ready) begin
          state_d     = StIdle;
          rsp_valid_d = 1'b0;
          ptr_d       = ~rsp_id_q;
        end
      end

      default: begin
        state_d     = StIdle;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      ptr_q       <= 1'b0;
      rem_q       <= 5'd0;
      acc_q       <= 32'd0;
      type_q      <= ShSll;
      id_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 32'd0;
      rsp_id_q    <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      rem_q       <= rem_d;
      acc_q       <= acc_d;
      type_q      <= type_d;
      id_q        <= id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_id_q    <= rsp_id_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_err   = rsp_err_q;

`ifndef SYNTHESIS
  ready_onehot_a: assert property (@(posedge clk) !(req_ready_0 && req_ready_1));
  rsp_hold_a: assert property (@(posedge clk) disable iff (!rst_n)
    rsp_valid && !rsp_ready |=> rsp_valid && $stable(rsp_data) && $stable(rsp_id)
                                && $stable(rsp_err));
`endif

endmodule

// File: tb/tb_shift_seq_ctrl.sv
module tb_shift_seq_ctrl;

  localparam int Step = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid_0 = 1'b0, req_valid_1 = 1'b0;
  logic        req_ready_0, req_ready_1;
  logic [31:0] req_a_0 = '0, req_a_1 = '0;
  logic [4:0]  req_shamt_0 = '0, req_shamt_1 = '0;
  logic [1:0]  req_type_0 = '0, req_type_1 = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_data;
  logic        rsp_id;
  logic        rsp_err;

  shift_seq_ctrl #(.STEP_MAX(Step)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid_0 (req_valid_0),
    .req_valid_1 (req_valid_1),
    .req_ready_0 (req_ready_0),
    .req_ready_1 (req_ready_1),
    .req_a_0     (req_a_0),
    .req_a_1     (req_a_1),
    .req_shamt_0 (req_shamt_0),
    .req_shamt_1 (req_shamt_1),
    .req_type_0  (req_type_0),
    .req_type_1  (req_type_1),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .rsp_id      (rsp_id),
    .rsp_err     (rsp_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        id;
    logic        err;
    int          due;
  } exp_t;

  exp_t        sb[$];
  int          grant_log[$];
  int          n_tests = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          last_acc_cyc = -1;
  int          last_hs_cyc = -1;
  int          n_rise = 0;
  logic [31:0] last_data = '0;
  logic        last_id = 1'b0;
  logic        last_err = 1'b0;
  logic        prev_valid = 1'b0, prev_ready = 1'b0;
  logic [31:0] prev_data = '0;
  logic        prev_id = 1'b0, prev_err = 1'b0;
  bit          rnd_mode = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] model(input logic [31:0] a, input logic [4:0] sh,
                                        input logic [1:0] ty);
    case (ty)
      2'b00:   return a << sh;
      2'b01:   return a >> sh;
      2'b10:   return $unsigned($signed(a) >>> sh);
      default: return a;
    endcase
  endfunction

  function automatic int shift_cycles(input logic [4:0] sh, input logic [1:0] ty);
    if (ty == 2'b11) return 0;
    return (int'(sh) + Step - 1) / Step;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: push expectations on acceptance, check on response.
  always @(negedge clk) begin
    if (!rst_n) begin
      check("ready0_in_reset", {31'd0, req_ready_0}, 32'd0);
      check("ready1_in_reset", {31'd0, req_ready_1}, 32'd0);
      sb.delete();
      prev_valid = 1'b0;
      prev_ready = 1'b0;
    end else begin
      exp_t e;
      if (req_ready_0 && req_ready_1) check("ready_both", 32'd1, 32'd0);
      if (req_valid_0 && req_ready_0) begin
        e.data = model(req_a_0, req_shamt_0, req_type_0);
        e.id = 1'b0;
        e.err = (req_type_0 == 2'b11);
        e.due = cyc + 1 + shift_cycles(req_shamt_0, req_type_0);
        sb.push_back(e);
        grant_log.push_back(0);
        last_acc_cyc = cyc;
      end
      if (req_valid_1 && req_ready_1) begin
        e.data = model(req_a_1, req_shamt_1, req_type_1);
        e.id = 1'b1;
        e.err = (req_type_1 == 2'b11);
        e.due = cyc + 1 + shift_cycles(req_shamt_1, req_type_1);
        sb.push_back(e);
        grant_log.push_back(1);
        last_acc_cyc = cyc;
      end
      if (rsp_valid) begin
        check("ready_in_resp", {31'd0, req_ready_0 | req_ready_1}, 32'd0);
        if (!prev_valid) begin
          n_rise++;
          if (sb.size() == 0) check("rsp_unexpected", 32'd1, 32'd0);
          else check("rsp_latency", cyc, sb[0].due);
        end else if (!prev_ready) begin
          check("hold_data", rsp_data, prev_data);
          check("hold_id", {31'd0, rsp_id}, {31'd0, prev_id});
          check("hold_err", {31'd0, rsp_err}, {31'd0, prev_err});
        end
        if (rsp_ready && sb.size() != 0) begin
          e = sb.pop_front();
          check("rsp_data", rsp_data, e.data);
          check("rsp_id", {31'd0, rsp_id}, {31'd0, e.id});
          check("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
          last_data = rsp_data;
          last_id = rsp_id;
          last_err = rsp_err;
          last_hs_cyc = cyc;
        end
      end
      prev_valid = rsp_valid;
      prev_ready = rsp_ready;
      prev_data = rsp_data;
      prev_id = rsp_id;
      prev_err = rsp_err;
    end
  end

  always @(posedge clk) begin
    if (rnd_mode) begin
      #1 rsp_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Caller is at #1 after a rising edge; returns at #1 after the accepting edge.
  task automatic issue(input int r, input logic [31:0] a, input logic [4:0] sh,
                       input logic [1:0] ty);
    int  n = 0;
    bit  done = 1'b0;
    if (r == 0) begin
      req_a_0 = a; req_shamt_0 = sh; req_type_0 = ty; req_valid_0 = 1'b1;
    end else begin
      req_a_1 = a; req_shamt_1 = sh; req_type_1 = ty; req_valid_1 = 1'b1;
    end
    while (!done && n < 300) begin
      @(negedge clk);
      if ((r == 0) ? req_ready_0 : req_ready_1) done = 1'b1;
      n++;
    end
    @(posedge clk);
    #1;
    if (r == 0) req_valid_0 = 1'b0;
    else req_valid_1 = 1'b0;
    check("accept_timeout", {31'd0, done}, 32'd1);
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || rsp_valid) && n < 500) begin
      @(negedge clk);
      n++;
    end
    #1;
    check("drain", sb.size(), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int cycles);
    rst_n = 1'b0;
    repeat (cycles) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int g0, h, r0;

    // Reset values, with a request held high to show ready stays low.
    req_valid_0 = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_data", rsp_data, 32'd0);
    check("rst_id", {31'd0, rsp_id}, 32'd0);
    check("rst_err", {31'd0, rsp_err}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    req_valid_0 = 1'b0;
    @(posedge clk);
    #1;

    // SLL by 4
    issue(0, 32'h8000_0001, 5'd4, 2'b00);
    drain();
    check("sll_data", last_data, 32'h0000_0010);
    check("sll_id", {31'd0, last_id}, 32'd0);

    // SRA / SRL by 31 from requester 1
    issue(1, 32'h8000_0000, 5'd31, 2'b10);
    drain();
    check("sra_data", last_data, 32'hFFFF_FFFF);
    check("sra_id", {31'd0, last_id}, 32'd1);
    issue(1, 32'h8000_0000, 5'd31, 2'b01);
    drain();
    check("srl_data", last_data, 32'h0000_0001);

    // Illegal type passes operand through with error flag
    issue(0, 32'h1234_5678, 5'd7, 2'b11);
    drain();
    check("ill_data", last_data, 32'h1234_5678);
    check("ill_err", {31'd0, last_err}, 32'd1);

    // Both valid after reset: grants alternate starting at 0
    do_reset(2);
    @(posedge clk);
    #1;
    g0 = grant_log.size();
    fork
      for (int i = 0; i < 3; i++) issue(0, 32'hA5A5_0000 + i, 5'd0, 2'b00);
      for (int j = 0; j < 3; j++) issue(1, 32'h5A5A_0000 + j, 5'd0, 2'b01);
    join
    drain();
    for (int k = 0; k < 6; k++) begin
      check("rr_order", grant_log.size() > g0 + k ? grant_log[g0 + k] : -1, k % 2);
    end

    // Stalled response; waiting requester accepted right after the handshake
    rsp_ready = 1'b0;
    h = -1;
    fork
      issue(0, 32'h0000_00F0, 5'd0, 2'b00);
      issue(1, 32'h0000_0F00, 5'd3, 2'b01);
      begin
        int n = 0;
        do begin
          @(negedge clk);
          n++;
        end while (!rsp_valid && n < 50);
        repeat (3) @(posedge clk);
        #1 rsp_ready = 1'b1;
        @(negedge clk);
        #1 h = last_hs_cyc;
      end
    join
    check("acc_after_hs", last_acc_cyc, h + 1);
    drain();

    // Reset in the middle of a long shift abandons it
    issue(0, 32'hDEAD_BEEF, 5'd31, 2'b00);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    r0 = n_rise;
    repeat (10) @(posedge clk);
    #1;
    check("no_rsp_after_rst", n_rise - r0, 32'd0);
    g0 = grant_log.size();
    fork
      issue(0, 32'h0000_0003, 5'd9, 2'b00);
      issue(1, 32'h0000_0C00, 5'd2, 2'b01);
    join
    drain();
    check("post_rst_first", grant_log.size() > g0 ? grant_log[g0] : -1, 32'd0);
    check("post_rst_second", grant_log.size() > g0 + 1 ? grant_log[g0 + 1] : -1, 32'd1);

    // Random traffic with random back-pressure
    rnd_mode = 1'b1;
    for (int k = 0; k < 20; k++) begin
      issue($urandom_range(0, 1), $urandom, 5'($urandom_range(0, 31)),
            2'($urandom_range(0, 3)));
    end
    rnd_mode = 1'b0;
    @(posedge clk);
    #2 rsp_ready = 1'b1;
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
